// File: rtl/flood_pkg.sv
// rtl/flood_pkg.sv - shared types and constants for the colour-select controller
// Contents: COLOR_W / MAX_COLORS constants, sel_state_t handshake states,
//           clamp_colors() helper mapping COLOR_NUM onto the legal 1..MAX_COLORS range.
package flood_pkg;

    localparam int COLOR_W    = 3;
    localparam int MAX_COLORS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sel_state_t;

    // 0 would leave the cursor nowhere to live, so it is treated as a single colour.
    function automatic logic [3:0] clamp_colors(input logic [3:0] num);
        logic [3:0] res;
        if (num > 4'(MAX_COLORS)) begin
            res = 4'(MAX_COLORS);
        end else if (num == 4'd0) begin
            res = 4'd1;
        end else begin
            res = num;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, debounce counter and rising-edge pulse
// Ports: clk_i, resetn_i (sync active-low), btn_i (raw, asynchronous),
//        pulse_o (1-cycle pulse on an accepted 0->1 stable transition).
// Parameter: DEBOUNCE_CYCLES - consecutive equal samples needed to accept a new level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only advances while the synchronised input disagrees with the
    // accepted level; any sample that agrees restarts the qualification window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            pulse_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_i;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            cnt_q         <= cnt_d;
            stable_prev_q <= stable_q;
            pulse_q       <= stable_q & ~stable_prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/color_select_ctrl.sv
// rtl/color_select_ctrl.sv - player-side colour-change request initiator with palette cursor
// Ports: CLOCK, RESET_N (sync active-low); BTN_LEFT/RIGHT/SELECT raw buttons;
//        COLOR_NUM, CURRENT_COLOR, INITIAL_INIT, START_NEW_GAME, CHANGING_COLOR from game logic;
//        COLOR_SELECTED, COLOR_SEL_SIG (request), CURSOR, MOVE_COUNT, BUSY, REJECT outputs.
// Option: MOVE_LIMIT_EN adds OUT_OF_MOVES and refuses selects once MOVE_LIMIT moves are made.
module color_select_ctrl
    import flood_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MOVE_W          = 6,
    parameter int MOVE_LIMIT      = 25
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               BTN_LEFT,
    input  logic               BTN_RIGHT,
    input  logic               BTN_SELECT,
    input  logic [3:0]         COLOR_NUM,
    input  logic [COLOR_W-1:0] CURRENT_COLOR,
    input  logic               INITIAL_INIT,
    input  logic               START_NEW_GAME,
    input  logic               CHANGING_COLOR,
    output logic [COLOR_W-1:0] COLOR_SELECTED,
    output logic               COLOR_SEL_SIG,
    output logic [COLOR_W-1:0] CURSOR,
    output logic [MOVE_W-1:0]  MOVE_COUNT,
    output logic               BUSY,
`ifdef MOVE_LIMIT_EN
    output logic               OUT_OF_MOVES,
`endif
    output logic               REJECT
);

    logic left_p, right_p, select_p;
    logic enable;
    logic left_e, right_e, select_e;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk_i(CLOCK), .resetn_i(RESET_N), .btn_i(BTN_LEFT), .pulse_o(left_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk_i(CLOCK), .resetn_i(RESET_N), .btn_i(BTN_RIGHT), .pulse_o(right_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
        .clk_i(CLOCK), .resetn_i(RESET_N), .btn_i(BTN_SELECT), .pulse_o(select_p)
    );

    assign enable   = INITIAL_INIT & ~START_NEW_GAME;
    assign left_e   = left_p & enable;
    assign right_e  = right_p & enable;
    assign select_e = select_p & enable;

    sel_state_t          state_q, state_d;
    logic                sig_q, sig_d;
    logic [COLOR_W-1:0]  sel_q, sel_d;
    logic [COLOR_W-1:0]  cursor_q, cursor_d;
    logic [MOVE_W-1:0]   move_q, move_d;
    logic                reject_q, reject_d;
    logic                blocked;

    logic [3:0]          n_colors;
    logic [3:0]          n_last;

    assign n_colors = clamp_colors(COLOR_NUM);
    assign n_last   = n_colors - 4'd1;

`ifdef MOVE_LIMIT_EN
    localparam logic [MOVE_W-1:0] LIMIT_V = MOVE_W'(MOVE_LIMIT);
    assign OUT_OF_MOVES = (move_q >= LIMIT_V);
    assign blocked      = OUT_OF_MOVES;
`else
    assign blocked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        sel_d    = sel_q;
        move_d   = move_q;
        reject_d = 1'b0;
        cursor_d = cursor_q;

        // Cursor is independent of the handshake state; an out-of-range cursor
        // (palette shrank) is pulled home before any button is honoured.
        if ({1'b0, cursor_q} >= n_colors) begin
            cursor_d = '0;
        end else if (left_e && !right_e) begin
            cursor_d = (cursor_q == '0) ? n_last[COLOR_W-1:0] : cursor_q - 1'b1;
        end else if (right_e && !left_e) begin
            cursor_d = ({1'b0, cursor_q} == n_last) ? '0 : cursor_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (select_e) begin
                    // cursor_q is the pre-move value even if a move pulse coincides.
                    if ((cursor_q != CURRENT_COLOR) && !blocked) begin
                        sel_d   = cursor_q;
                        sig_d   = 1'b1;
                        state_d = REQ;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (CHANGING_COLOR) begin
                    sig_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!CHANGING_COLOR) begin
                    if (move_q != '1) begin
                        move_d = move_q + 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sig_d   = 1'b0;
            end
        endcase

        // New game overrides everything, including the cursor.
        if (START_NEW_GAME) begin
            state_d  = IDLE;
            sig_d    = 1'b0;
            move_d   = '0;
            cursor_d = '0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            sig_q    <= 1'b0;
            sel_q    <= '0;
            cursor_q <= '0;
            move_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            sel_q    <= sel_d;
            cursor_q <= cursor_d;
            move_q   <= move_d;
            reject_q <= reject_d;
        end
    end

    assign COLOR_SELECTED = sel_q;
    assign COLOR_SEL_SIG  = sig_q;
    assign CURSOR         = cursor_q;
    assign MOVE_COUNT     = move_q;
    assign BUSY           = (state_q != IDLE);
    assign REJECT         = reject_q;

endmodule

// File: tb/tb_color_select_ctrl.sv
// tb/tb_color_select_ctrl.sv - directed self-checking bench for color_select_ctrl
module tb_color_select_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       BTN_LEFT = 1'b0, BTN_RIGHT = 1'b0, BTN_SELECT = 1'b0;
    logic [3:0] COLOR_NUM = 4'd6;
    logic [2:0] CURRENT_COLOR = 3'd0;
    logic       INITIAL_INIT = 1'b1;
    logic       START_NEW_GAME = 1'b0;
    logic       CHANGING_COLOR = 1'b0;
    logic [2:0] COLOR_SELECTED;
    logic       COLOR_SEL_SIG;
    logic [2:0] CURSOR;
    logic [5:0] MOVE_COUNT;
    logic       BUSY;
    logic       REJECT;
`ifdef MOVE_LIMIT_EN
    logic       OUT_OF_MOVES;
`endif

    color_select_ctrl #(.DEBOUNCE_CYCLES(4), .MOVE_W(6), .MOVE_LIMIT(2)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .BTN_LEFT(BTN_LEFT), .BTN_RIGHT(BTN_RIGHT), .BTN_SELECT(BTN_SELECT),
        .COLOR_NUM(COLOR_NUM), .CURRENT_COLOR(CURRENT_COLOR),
        .INITIAL_INIT(INITIAL_INIT), .START_NEW_GAME(START_NEW_GAME),
        .CHANGING_COLOR(CHANGING_COLOR),
        .COLOR_SELECTED(COLOR_SELECTED), .COLOR_SEL_SIG(COLOR_SEL_SIG),
        .CURSOR(CURSOR), .MOVE_COUNT(MOVE_COUNT), .BUSY(BUSY),
`ifdef MOVE_LIMIT_EN
        .OUT_OF_MOVES(OUT_OF_MOVES),
`endif
        .REJECT(REJECT)
    );

    always #5 CLOCK = ~CLOCK;

    int tests = 0;
    int fails = 0;
    int reject_cycles = 0;
    int sig_rises = 0;
    logic sig_prev = 1'b0;
    logic [2:0] exp_q[$];
    int exp_cursor = 0;
    int exp_moves = 0;
    int ncol = 6;

    always @(negedge CLOCK) begin
        if (REJECT === 1'b1) reject_cycles++;
        if (COLOR_SEL_SIG === 1'b1 && sig_prev !== 1'b1) sig_rises++;
        sig_prev = COLOR_SEL_SIG;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 left, 1 right, 2 select
    task automatic press(input int which, input int hold);
        case (which)
            0: BTN_LEFT = 1'b1;
            1: BTN_RIGHT = 1'b1;
            default: BTN_SELECT = 1'b1;
        endcase
        tick(hold);
        BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_SELECT = 1'b0;
        tick(12);
    endtask

    task automatic move_left(input string tag);
        press(0, 10);
        exp_cursor = (exp_cursor == 0) ? ncol - 1 : exp_cursor - 1;
        check(tag, 32'(CURSOR), 32'(exp_cursor));
    endtask

    task automatic move_right(input string tag);
        press(1, 10);
        exp_cursor = (exp_cursor == ncol - 1) ? 0 : exp_cursor + 1;
        check(tag, 32'(CURSOR), 32'(exp_cursor));
    endtask

    // Select expected to launch a request; the scoreboard holds the colour it must carry.
    task automatic select_request(input string tag);
        int rises0;
        logic [2:0] exp_col;
        rises0 = sig_rises;
        exp_q.push_back(3'(exp_cursor));
        press(2, 10);
        check({tag, "_sig"}, 32'(COLOR_SEL_SIG), 32'd1);
        check({tag, "_rises"}, 32'(sig_rises - rises0), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_col = exp_q.pop_front();
            check({tag, "_color"}, 32'(COLOR_SELECTED), 32'(exp_col));
        end
        check({tag, "_busy"}, 32'(BUSY), 32'd1);
    endtask

    task automatic complete_move(input string tag);
        CHANGING_COLOR = 1'b1;
        tick(1);
        check({tag, "_sig_drop"}, 32'(COLOR_SEL_SIG), 32'd0);
        check({tag, "_busy_wait"}, 32'(BUSY), 32'd1);
        tick(3);
        CHANGING_COLOR = 1'b0;
        check({tag, "_move_before"}, 32'(MOVE_COUNT), 32'(exp_moves));
        tick(1);
        exp_moves++;
        check({tag, "_move_after"}, 32'(MOVE_COUNT), 32'(exp_moves));
        check({tag, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int rej0, rises0;

        // Reset
        tick(3);
        check("rst_sel", 32'(COLOR_SELECTED), 32'd0);
        check("rst_sig", 32'(COLOR_SEL_SIG), 32'd0);
        check("rst_cursor", 32'(CURSOR), 32'd0);
        check("rst_moves", 32'(MOVE_COUNT), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_reject", 32'(REJECT), 32'd0);
        RESET_N = 1'b1;
        tick(2);

        // Debounce: a 3-cycle glitch is below threshold, a 10-cycle hold moves once
        press(1, 3);
        check("glitch_cursor", 32'(CURSOR), 32'd0);
        move_right("hold_cursor");

        // Wrap with 6 colours
        move_left("left_to_0");
        move_left("wrap_left");
        move_right("wrap_right");

        // 12 colours clamp to 8
        COLOR_NUM = 4'd12; ncol = 8;
        move_left("clamp_wrap_left");
        COLOR_NUM = 4'd6; ncol = 6;
        tick(2);
        exp_cursor = 0;
        check("shrink_cursor", 32'(CURSOR), 32'd0);

        // Handshake at cursor 3 with 8 colours
        COLOR_NUM = 4'd8; ncol = 8;
        move_right("to1");
        move_right("to2");
        move_right("to3");
        CURRENT_COLOR = 3'd1;
        select_request("hs");
        rej0 = reject_cycles; rises0 = sig_rises;
        press(2, 10);
        check("req_sel_no_reject", 32'(reject_cycles - rej0), 32'd0);
        check("req_still_sig", 32'(COLOR_SEL_SIG), 32'd1);
        CHANGING_COLOR = 1'b1;
        tick(1);
        check("hs_sig_drop", 32'(COLOR_SEL_SIG), 32'd0);
        press(2, 10);
        check("wait_sel_no_reject", 32'(reject_cycles - rej0), 32'd0);
        check("wait_sel_no_req", 32'(sig_rises - rises0), 32'd0);
        CHANGING_COLOR = 1'b0;
        check("hs_move_before", 32'(MOVE_COUNT), 32'd0);
        tick(1);
        exp_moves = 1;
        check("hs_move_after", 32'(MOVE_COUNT), 32'd1);
        check("hs_held_color", 32'(COLOR_SELECTED), 32'd3);

        // Refusal: cursor equals current colour
        move_left("to2_refuse");
        CURRENT_COLOR = 3'd2;
        rej0 = reject_cycles; rises0 = sig_rises;
        press(2, 10);
        check("refuse_reject", 32'(reject_cycles - rej0), 32'd1);
        check("refuse_sig", 32'(COLOR_SEL_SIG), 32'd0);
        check("refuse_no_req", 32'(sig_rises - rises0), 32'd0);

        // Abort in REQ with START_NEW_GAME
        CURRENT_COLOR = 3'd0;
        select_request("abort");
        START_NEW_GAME = 1'b1;
        tick(1);
        START_NEW_GAME = 1'b0;
        exp_cursor = 0; exp_moves = 0;
        check("abort_sig", 32'(COLOR_SEL_SIG), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_moves", 32'(MOVE_COUNT), 32'd0);
        check("abort_cursor", 32'(CURSOR), 32'd0);

        // Reset mid-WAIT
        CURRENT_COLOR = 3'd5;
        select_request("rstwait");
        CHANGING_COLOR = 1'b1;
        tick(2);
        check("rstwait_in_wait", 32'(BUSY), 32'd1);
        RESET_N = 1'b0;
        tick(1);
        check("rstwait_sel", 32'(COLOR_SELECTED), 32'd0);
        check("rstwait_sig", 32'(COLOR_SEL_SIG), 32'd0);
        check("rstwait_busy", 32'(BUSY), 32'd0);
        check("rstwait_moves", 32'(MOVE_COUNT), 32'd0);
        check("rstwait_cursor", 32'(CURSOR), 32'd0);
        CHANGING_COLOR = 1'b0;
        RESET_N = 1'b1;
        tick(2);
        exp_cursor = 0; exp_moves = 0;

`ifdef MOVE_LIMIT_EN
        check("lim_init", 32'(OUT_OF_MOVES), 32'd0);
        select_request("lim_m1");
        complete_move("lim_m1");
        check("lim_after1", 32'(OUT_OF_MOVES), 32'd0);
        select_request("lim_m2");
        complete_move("lim_m2");
        check("lim_after2", 32'(OUT_OF_MOVES), 32'd1);
        rej0 = reject_cycles; rises0 = sig_rises;
        press(2, 10);
        check("lim_reject", 32'(reject_cycles - rej0), 32'd1);
        check("lim_no_req", 32'(sig_rises - rises0), 32'd0);
        START_NEW_GAME = 1'b1;
        tick(1);
        START_NEW_GAME = 1'b0;
        check("lim_cleared", 32'(OUT_OF_MOVES), 32'd0);
`else
        select_request("m1");
        complete_move("m1");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
